clock_time_core: RTL

Timekeeping and edit core fed by the mode selector's `state_mode`. It holds the running BCD time (hh:mm:ss) and the alarm time (hh:mm). It advances time from an internal 1 Hz prescaler and applies debounced set and increment keypresses to the time or alarm fields, depending on the mode. Its outputs drive the display mux and the alarm/buzzer stage.

---
 rtl/clock_pkg.sv | 56 +++++
 rtl/key_debounce.sv | 54 +++++
 rtl/clock_time_core.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clock_pkg                                                                  |
// | Shared constants, types and BCD helper for the clock timekeeping core.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package clock_pkg;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_TIME = 2'd1;
    localparam logic [1:0] MODE_SHOW_ALM = 2'd2;
    localparam logic [1:0] MODE_SET_ALM  = 2'd3;

    localparam logic [7:0] BCD_HH_MAX   = 8'h23;
    localparam logic [7:0] BCD_MS_MAX   = 8'h59;
    localparam logic [7:0] ALARM_HH_RST = 8'h07;

    typedef enum logic [1:0] {
        FLD_NONE = 2'd0,
        FLD_HH   = 2'd1,
        FLD_MM   = 2'd2,
        FLD_SS   = 2'd3
    } edit_fld_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ED_HH = 2'd1,
        ED_MM = 2'd2,
        ED_SS = 2'd3
    } edit_state_t;

    // Two-digit BCD increment that wraps to 00 once the limit is reached.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] lim);
        logic [7:0] res;
        if (val >= lim)
            res = 8'h00;
        else if (val[3:0] == 4'd9)
            res = {val[7:4] + 4'd1, 4'd0};
        else
            res = {val[7:4], val[3:0] + 4'd1};
        return res;
    endfunction

    function automatic edit_fld_t to_field(input edit_state_t st);
        edit_fld_t f;
        case (st)
            ED_HH:   f = FLD_HH;
            ED_MM:   f = FLD_MM;
            ED_SS:   f = FLD_SS;
            default: f = FLD_NONE;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_debounce                                                               |
// | Two-flop synchronizer, stability counter and rising-edge pulse for a key.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_pulse
);

    localparam int c_CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE_CYC - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic [c_CW-1:0] r_cnt;
    logic            r_level;
    logic            r_level_d;
    logic            r_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync1   <= i_key;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_pulse   <= r_level & ~r_level_d;
            // Any sample agreeing with the accepted level restarts the run.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/clock_time_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clock_time_core                                                            |
// | Running BCD time, alarm registers, 1 Hz prescaler and key-driven editing.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module clock_time_core
    import clock_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic [3:0] state_mode,
    input  logic       key_sel,
    input  logic       key_add,
    output logic [7:0] time_hh,
    output logic [7:0] time_mm,
    output logic [7:0] time_ss,
    output logic [7:0] alarm_hh,
    output logic [7:0] alarm_mm,
    output logic [7:0] disp_hh,
    output logic [7:0] disp_mm,
    output logic [7:0] disp_ss,
    output logic [1:0] edit_field,
    output logic       sec_tick,
    output logic       alarm_hit
);

    localparam int c_PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(CLK_FREQ - 1);

    logic [c_PW-1:0] r_presc;
    logic            r_sec_tick;
    logic            r_alarm_hit;
    logic [1:0]      r_mode_q;
    edit_state_t     r_state;
    logic [7:0]      r_hh, r_mm, r_ss;
    logic [7:0]      r_alm_hh, r_alm_mm;
    logic [7:0]      r_disp_hh, r_disp_mm, r_disp_ss;

    logic            w_sel_p, w_add_p;
    logic [1:0]      w_mode;
    logic            w_mode_chg, w_editing, w_edit_ok;
    logic            w_add_time, w_add_alm, w_show_time;
    logic [c_PW-1:0] w_presc_nxt;
    logic [7:0]      w_hh_nxt, w_mm_nxt, w_ss_nxt;
    logic [7:0]      w_alm_hh_nxt, w_alm_mm_nxt;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_sel (
        .clk     (clk_50M),
        .rst     (rst),
        .i_key   (key_sel),
        .o_pulse (w_sel_p)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_add (
        .clk     (clk_50M),
        .rst     (rst),
        .i_key   (key_add),
        .o_pulse (w_add_p)
    );

    always_comb begin
        w_mode      = (state_mode > 4'd3) ? MODE_RUN : state_mode[1:0];
        w_mode_chg  = (w_mode != r_mode_q);
        w_editing   = (w_mode == MODE_SET_TIME) || (w_mode == MODE_SET_ALM);
        // Keys are ignored in the cycle a mode change re-targets the FSM.
        w_edit_ok   = w_editing && !w_mode_chg && (r_state != IDLE);
        w_add_time  = w_edit_ok && w_add_p && (w_mode == MODE_SET_TIME);
        w_add_alm   = w_edit_ok && w_add_p && (w_mode == MODE_SET_ALM);
        w_show_time = (w_mode == MODE_RUN) || (w_mode == MODE_SET_TIME);

        if (w_mode == MODE_SET_TIME)
            w_presc_nxt = '0;
        else if (r_presc == c_PRESC_MAX)
            w_presc_nxt = '0;
        else
            w_presc_nxt = r_presc + c_PW'(1);
    end

    always_comb begin
        w_hh_nxt = r_hh;
        w_mm_nxt = r_mm;
        w_ss_nxt = r_ss;
        if (r_sec_tick) begin
            w_ss_nxt = bcd_inc(r_ss, BCD_MS_MAX);
            if (r_ss == BCD_MS_MAX) begin
                w_mm_nxt = bcd_inc(r_mm, BCD_MS_MAX);
                if (r_mm == BCD_MS_MAX)
                    w_hh_nxt = bcd_inc(r_hh, BCD_HH_MAX);
            end
        end else if (w_add_time) begin
            case (r_state)
                ED_HH:   w_hh_nxt = bcd_inc(r_hh, BCD_HH_MAX);
                ED_MM:   w_mm_nxt = bcd_inc(r_mm, BCD_MS_MAX);
                ED_SS:   w_ss_nxt = bcd_inc(r_ss, BCD_MS_MAX);
                default: w_hh_nxt = r_hh;
            endcase
        end
    end

    always_comb begin
        w_alm_hh_nxt = r_alm_hh;
        w_alm_mm_nxt = r_alm_mm;
        if (w_add_alm) begin
            case (r_state)
                ED_HH:   w_alm_hh_nxt = bcd_inc(r_alm_hh, BCD_HH_MAX);
                ED_MM:   w_alm_mm_nxt = bcd_inc(r_alm_mm, BCD_MS_MAX);
                default: w_alm_hh_nxt = r_alm_hh;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_presc     <= '0;
            r_sec_tick  <= 1'b0;
            r_alarm_hit <= 1'b0;
            r_mode_q    <= MODE_RUN;
            r_state     <= IDLE;
            r_hh        <= 8'h00;
            r_mm        <= 8'h00;
            r_ss        <= 8'h00;
            r_alm_hh    <= ALARM_HH_RST;
            r_alm_mm    <= 8'h00;
            r_disp_hh   <= 8'h00;
            r_disp_mm   <= 8'h00;
            r_disp_ss   <= 8'h00;
        end else begin
            r_presc    <= w_presc_nxt;
            r_sec_tick <= (w_mode != MODE_SET_TIME) && (w_presc_nxt == c_PRESC_MAX);
            r_mode_q   <= w_mode;
            r_hh       <= w_hh_nxt;
            r_mm       <= w_mm_nxt;
            r_ss       <= w_ss_nxt;
            r_alm_hh   <= w_alm_hh_nxt;
            r_alm_mm   <= w_alm_mm_nxt;

            r_alarm_hit <= r_sec_tick
                        && ((w_mode == MODE_RUN) || (w_mode == MODE_SHOW_ALM))
                        && (w_hh_nxt == r_alm_hh) && (w_mm_nxt == r_alm_mm)
                        && (w_ss_nxt == 8'h00);

            // Display tracks next-state values so it never lags the registers.
            if (w_show_time) begin
                r_disp_hh <= w_hh_nxt;
                r_disp_mm <= w_mm_nxt;
                r_disp_ss <= w_ss_nxt;
            end else begin
                r_disp_hh <= w_alm_hh_nxt;
                r_disp_mm <= w_alm_mm_nxt;
                r_disp_ss <= 8'h00;
            end

            if (w_mode_chg) begin
                r_state <= w_editing ? ED_HH : IDLE;
            end else if (!w_editing) begin
                r_state <= IDLE;
            end else if (w_sel_p) begin
                case (r_state)
                    ED_HH:   r_state <= ED_MM;
                    ED_MM:   r_state <= (w_mode == MODE_SET_TIME) ? ED_SS : ED_HH;
                    default: r_state <= ED_HH;
                endcase
            end
        end
    end

    assign time_hh    = r_hh;
    assign time_mm    = r_mm;
    assign time_ss    = r_ss;
    assign alarm_hh   = r_alm_hh;
    assign alarm_mm   = r_alm_mm;
    assign disp_hh    = r_disp_hh;
    assign disp_mm    = r_disp_mm;
    assign disp_ss    = r_disp_ss;
    assign edit_field = to_field(r_state);
    assign sec_tick   = r_sec_tick;
    assign alarm_hit  = r_alarm_hit;

endmodule
`default_nettype wire
